hssim_index_pipe: RTL



---
 rtl/hssim_pkg.sv | 21 ++
 rtl/hdiv_pipe.sv | 80 ++++++++
 rtl/hssim_index_pipe.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hssim_pkg.sv
// hssim_pkg: shared constants and types for the HSSIM index pipeline.
// Holds stabiliser defaults, datapath widths and the divider tag layout.
package hssim_pkg;

  localparam logic [17:0] C1_DEF = 18'd7;
  localparam logic [17:0] C2_DEF = 18'd59;

  localparam int unsigned MU_W          = 8;
  localparam int unsigned SIG_W         = 17;
  localparam int unsigned NUM_W         = 37;
  localparam int unsigned SSIM_W        = 10;
  localparam int unsigned FRAC_BITS_DEF = 8;
  localparam int unsigned ACC_W_DEF     = 32;
  localparam int unsigned HSSIM_IDX_LAT = 12;

  typedef struct packed {
    logic sign;
    logic last;
  } hdiv_tag_t;

endpackage

// File: rtl/hdiv_pipe.sv
// hdiv_pipe: pipelined restoring divider, one quotient bit per stage,
// with a valid/tag sideband and an overflow flag for quotients >= 2^Q_W.
module hdiv_pipe #(
  parameter int unsigned DVD_W = 44,
  parameter int unsigned DIV_W = 37,
  parameter int unsigned Q_W   = 9,
  parameter int unsigned TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [Q_W-1:0]   o_quot,
  output logic             o_ovf,
  output logic [TAG_W-1:0] o_tag
);
  localparam int unsigned R_W = (DVD_W > DIV_W + Q_W) ? DVD_W : DIV_W + Q_W;

  logic             r_valid [Q_W];
  logic             r_ovf   [Q_W];
  logic [R_W-1:0]   r_rem   [Q_W];
  logic [DIV_W-1:0] r_den   [Q_W];
  logic [Q_W-1:0]   r_quo   [Q_W];
  logic [TAG_W-1:0] r_tag   [Q_W];

  logic             w_valid [Q_W];
  logic             w_ovf   [Q_W];
  logic [R_W-1:0]   w_rem   [Q_W];
  logic [DIV_W-1:0] w_den   [Q_W];
  logic [Q_W-1:0]   w_quo   [Q_W];
  logic [TAG_W-1:0] w_tag   [Q_W];
  logic [R_W-1:0]   w_trial [Q_W];
  logic             w_ge    [Q_W];

  // Overflow is decided once up front; later stages rely on rem < den << (bit+1).
  always_comb begin
    w_valid[0] = i_valid;
    w_ovf[0]   = R_W'(i_dividend) >= (R_W'(i_divisor) << Q_W);
    w_rem[0]   = R_W'(i_dividend);
    w_den[0]   = i_divisor;
    w_quo[0]   = '0;
    w_tag[0]   = i_tag;
    for (int s = 1; s < Q_W; s++) begin
      w_valid[s] = r_valid[s-1];
      w_ovf[s]   = r_ovf[s-1];
      w_rem[s]   = r_rem[s-1];
      w_den[s]   = r_den[s-1];
      w_quo[s]   = r_quo[s-1];
      w_tag[s]   = r_tag[s-1];
    end
  end

  always_comb begin
    for (int s = 0; s < Q_W; s++) begin
      w_trial[s] = R_W'(w_den[s]) << (Q_W - 1 - s);
      w_ge[s]    = w_rem[s] >= w_trial[s];
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < Q_W; s++) begin
      if (rst) r_valid[s] <= 1'b0;
      else     r_valid[s] <= w_valid[s];
      r_ovf[s] <= w_ovf[s];
      r_rem[s] <= w_ge[s] ? w_rem[s] - w_trial[s] : w_rem[s];
      r_den[s] <= w_den[s];
      r_quo[s] <= {w_quo[s][Q_W-2:0], w_ge[s]};
      r_tag[s] <= w_tag[s];
    end
  end

  assign o_valid = r_valid[Q_W-1];
  assign o_quot  = r_quo[Q_W-1];
  assign o_ovf   = r_ovf[Q_W-1];
  assign o_tag   = r_tag[Q_W-1];

endmodule

// File: rtl/hssim_index_pipe.sv
// hssim_index_pipe: streaming SSIM index (Q1.8), 12-cycle latency, plus frame sum/count.
// Build option HSSIM_CLAMP_NEG_EN forces negative indices (and their accumulation) to zero.
module hssim_index_pipe
  import hssim_pkg::*;
#(
  parameter logic [17:0] C1        = C1_DEF,
  parameter logic [17:0] C2        = C2_DEF,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [MU_W-1:0]          mu_ref,
  input  logic [MU_W-1:0]          mu_dist,
  input  logic signed [SIG_W-1:0]  sig_ref_sqrd,
  input  logic signed [SIG_W-1:0]  sig_dist_sqrd,
  input  logic signed [SIG_W-1:0]  sig_refdist,
  output logic                     out_valid,
  output logic signed [SSIM_W-1:0] ssim_idx,
  output logic                     frame_valid,
  output logic signed [ACC_W-1:0]  frame_sum,
  output logic [23:0]              frame_cnt
);
  localparam int unsigned MAG_W = NUM_W - 1;
  localparam int unsigned DVD_W = MAG_W + FRAC_BITS;
  localparam int unsigned Q_W   = FRAC_BITS + 1;
  localparam logic [Q_W-1:0] SAT = Q_W'(1) << FRAC_BITS;

  logic [17:0] w_mr, w_md;
  logic [18:0] w_vr, w_vd;
  assign w_mr = 18'(mu_ref);
  assign w_md = 18'(mu_dist);
  assign w_vr = sig_ref_sqrd[SIG_W-1]  ? '0 : {2'b00, sig_ref_sqrd};
  assign w_vd = sig_dist_sqrd[SIG_W-1] ? '0 : {2'b00, sig_dist_sqrd};

  logic               r_s1_valid, r_s1_last;
  logic [17:0]        r_a, r_d1;
  logic signed [18:0] r_b;
  logic [18:0]        r_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_last  <= in_valid & in_last;
    end
    r_a  <= ((w_mr * w_md) << 1) + C1;
    r_b  <= {sig_refdist[SIG_W-1], sig_refdist, 1'b0} + 19'(C2);
    r_d1 <= w_mr * w_mr + w_md * w_md + C1;
    r_d2 <= w_vr + w_vd + 19'(C2);
  end

  // A is always positive, so |NUM| = A*|B| and the sign of NUM is the sign of B.
  logic [18:0]      w_babs;
  logic             r_s2_valid, r_s2_last, r_s2_sign;
  logic [MAG_W-1:0] r_num_mag;
  logic [NUM_W-1:0] r_den;
  assign w_babs = r_b[18] ? -r_b : r_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
    end
    r_s2_sign <= r_b[18];
    r_num_mag <= MAG_W'(r_a) * MAG_W'(w_babs);
    r_den     <= NUM_W'(r_d1) * NUM_W'(r_d2);
  end

  logic [DVD_W-1:0] w_dividend;
  hdiv_tag_t        w_tag_in, w_tag_out;
  logic             w_d_valid, w_d_ovf;
  logic [Q_W-1:0]   w_d_quo;
  assign w_dividend = DVD_W'(r_num_mag) << FRAC_BITS;
  assign w_tag_in   = '{sign: r_s2_sign, last: r_s2_last};

  hdiv_pipe #(
    .DVD_W(DVD_W),
    .DIV_W(NUM_W),
    .Q_W  (Q_W),
    .TAG_W($bits(hdiv_tag_t))
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (r_s2_valid),
    .i_dividend(w_dividend),
    .i_divisor (r_den),
    .i_tag     (w_tag_in),
    .o_valid   (w_d_valid),
    .o_quot    (w_d_quo),
    .o_ovf     (w_d_ovf),
    .o_tag     (w_tag_out)
  );

  logic [Q_W-1:0]           w_mag;
  logic signed [SSIM_W-1:0] w_idx, w_out;
  assign w_mag = (w_d_ovf || (w_d_quo > SAT)) ? SAT : w_d_quo;
  assign w_idx = w_tag_out.sign ? -SSIM_W'(w_mag) : SSIM_W'(w_mag);
`ifdef HSSIM_CLAMP_NEG_EN
  assign w_out = w_idx[SSIM_W-1] ? '0 : w_idx;
`else
  assign w_out = w_idx;
`endif

  logic                    r_out_valid, r_frame_valid;
  logic signed [SSIM_W-1:0] r_ssim;
  logic signed [ACC_W-1:0] r_run_sum, r_frame_sum, w_sum_nxt;
  logic [23:0]             r_run_cnt, r_frame_cnt, w_cnt_nxt;
  assign w_sum_nxt = r_run_sum + ACC_W'(w_out);
  assign w_cnt_nxt = r_run_cnt + 24'd1;

  // Frame totals include the last pixel; running totals restart in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_ssim        <= '0;
      r_run_sum     <= '0;
      r_run_cnt     <= '0;
      r_frame_sum   <= '0;
      r_frame_cnt   <= '0;
    end else begin
      r_out_valid   <= w_d_valid;
      r_frame_valid <= 1'b0;
      if (w_d_valid) begin
        r_ssim <= w_out;
        if (w_tag_out.last) begin
          r_frame_sum   <= w_sum_nxt;
          r_frame_cnt   <= w_cnt_nxt;
          r_run_sum     <= '0;
          r_run_cnt     <= '0;
          r_frame_valid <= 1'b1;
        end else begin
          r_run_sum <= w_sum_nxt;
          r_run_cnt <= w_cnt_nxt;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign ssim_idx    = r_ssim;
  assign frame_valid = r_frame_valid;
  assign frame_sum   = r_frame_sum;
  assign frame_cnt   = r_frame_cnt;

endmodule
